// File: rtl/nf10_1g_rx_arbiter.sv
// nf10_1g_rx_arbiter: packet-granular round-robin merge of the two 1G rx AXI-Stream ports,
// tagging each packet with its source port and keeping per-port packet/error counters.
module nf10_1g_rx_arbiter #(
    parameter int C_DATA_WIDTH = 8,
    parameter int C_CNT_WIDTH  = 32
) (
    input  logic                      axi_aclk,
    input  logic                      axi_resetn,
    input  logic [C_DATA_WIDTH-1:0]   s_axis_tdata_0,
    input  logic [C_DATA_WIDTH/8-1:0] s_axis_tstrb_0,
    input  logic                      s_axis_tvalid_0,
    output logic                      s_axis_tready_0,
    input  logic                      s_axis_tlast_0,
    input  logic                      s_axis_err_tvalid_0,
    input  logic [C_DATA_WIDTH-1:0]   s_axis_tdata_1,
    input  logic [C_DATA_WIDTH/8-1:0] s_axis_tstrb_1,
    input  logic                      s_axis_tvalid_1,
    output logic                      s_axis_tready_1,
    input  logic                      s_axis_tlast_1,
    input  logic                      s_axis_err_tvalid_1,
    output logic [C_DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [C_DATA_WIDTH/8-1:0] m_axis_tstrb,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic                      m_axis_tlast,
    output logic                      m_axis_tuser,
    output logic                      m_axis_err_tvalid,
    output logic [C_CNT_WIDTH-1:0]    pkt_cnt_0,
    output logic [C_CNT_WIDTH-1:0]    pkt_cnt_1,
    output logic [C_CNT_WIDTH-1:0]    err_cnt_0,
    output logic [C_CNT_WIDTH-1:0]    err_cnt_1
);
    typedef enum logic {IDLE, SEND} state_t;

    state_t                 r_state, w_state_nxt;
    logic                   r_grant, w_grant_nxt;
    logic                   r_last;
    logic [C_CNT_WIDTH-1:0] r_pkt_cnt_0, r_pkt_cnt_1, r_err_cnt_0, r_err_cnt_1;
    logic                   w_send, w_valid, w_tlast, w_err, w_eop;

    assign w_send  = r_state == SEND;
    assign w_valid = r_grant ? s_axis_tvalid_1 : s_axis_tvalid_0;
    assign w_tlast = r_grant ? s_axis_tlast_1 : s_axis_tlast_0;
    assign w_err   = r_grant ? s_axis_err_tvalid_1 : s_axis_err_tvalid_0;
    assign w_eop   = w_send & w_valid & m_axis_tready & w_tlast;

    // On a tie the port not served most recently wins
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        if (!w_send) begin
            if (s_axis_tvalid_0 | s_axis_tvalid_1) begin
                w_state_nxt = SEND;
                w_grant_nxt = (s_axis_tvalid_0 & s_axis_tvalid_1) ? ~r_last : s_axis_tvalid_1;
            end
        end else if (w_eop) begin
            w_state_nxt = IDLE;
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (!axi_resetn) begin
            r_state <= IDLE;
            r_grant <= 1'b0;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            if (w_eop)
                r_last <= r_grant;
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (!axi_resetn) begin
            r_pkt_cnt_0 <= '0;
            r_pkt_cnt_1 <= '0;
            r_err_cnt_0 <= '0;
            r_err_cnt_1 <= '0;
        end else if (w_eop) begin
            if (r_grant) begin
                r_pkt_cnt_1 <= r_pkt_cnt_1 + C_CNT_WIDTH'(1);
                if (w_err)
                    r_err_cnt_1 <= r_err_cnt_1 + C_CNT_WIDTH'(1);
            end else begin
                r_pkt_cnt_0 <= r_pkt_cnt_0 + C_CNT_WIDTH'(1);
                if (w_err)
                    r_err_cnt_0 <= r_err_cnt_0 + C_CNT_WIDTH'(1);
            end
        end
    end

    // Everything reads zero while IDLE so nothing leaks out between packets
    assign m_axis_tdata      = !w_send ? '0 : r_grant ? s_axis_tdata_1 : s_axis_tdata_0;
    assign m_axis_tstrb      = !w_send ? '0 : r_grant ? s_axis_tstrb_1 : s_axis_tstrb_0;
    assign m_axis_tvalid     = w_send & w_valid;
    assign m_axis_tlast      = w_send & w_tlast;
    assign m_axis_err_tvalid = w_send & w_err;
    assign m_axis_tuser      = w_send & r_grant;
    assign s_axis_tready_0   = w_send & ~r_grant & m_axis_tready;
    assign s_axis_tready_1   = w_send & r_grant & m_axis_tready;
    assign pkt_cnt_0         = r_pkt_cnt_0;
    assign pkt_cnt_1         = r_pkt_cnt_1;
    assign err_cnt_0         = r_err_cnt_0;
    assign err_cnt_1         = r_err_cnt_1;
endmodule

// File: tb/tb_nf10_1g_rx_arbiter.sv
// tb_nf10_1g_rx_arbiter: directed and randomised-traffic checks of the two-port rx arbiter
// using 4-bit counters so wrap-around is reachable quickly.
module tb_nf10_1g_rx_arbiter;
    typedef struct {
        int         len;
        bit         err;
        logic [7:0] base;
    } pkt_t;

    logic       clk = 1'b0;
    logic       rstn;
    logic [7:0] d [2];
    logic [0:0] s [2];
    logic       v [2];
    logic       r [2];
    logic       l [2];
    logic       e [2];
    logic [7:0] md;
    logic [0:0] ms;
    logic       mv, mr, ml, mu, me;
    logic [3:0] pc0, pc1, ec0, ec1;

    int         ncmp = 0;
    int         nerr = 0;
    pkt_t       sq [2][$];
    pkt_t       oq [2][$];
    int         beat [2];
    bit         pres [2];
    logic [7:0] nb [2];
    logic [3:0] pcnt [2];
    logic [3:0] ecnt [2];
    int         gap_pct = 0;
    int         rdy_pct = 100;
    bit         in_pkt, cur_src, ended;
    int         obeat;
    int         exp_src [$];
    int         cyc = 0;
    int         fv = -1;
    int         fo = -1;

    always #5 clk = ~clk;

    nf10_1g_rx_arbiter #(.C_DATA_WIDTH(8), .C_CNT_WIDTH(4)) dut (
        .axi_aclk(clk), .axi_resetn(rstn),
        .s_axis_tdata_0(d[0]), .s_axis_tstrb_0(s[0]), .s_axis_tvalid_0(v[0]), .s_axis_tready_0(r[0]),
        .s_axis_tlast_0(l[0]), .s_axis_err_tvalid_0(e[0]),
        .s_axis_tdata_1(d[1]), .s_axis_tstrb_1(s[1]), .s_axis_tvalid_1(v[1]), .s_axis_tready_1(r[1]),
        .s_axis_tlast_1(l[1]), .s_axis_err_tvalid_1(e[1]),
        .m_axis_tdata(md), .m_axis_tstrb(ms), .m_axis_tvalid(mv), .m_axis_tready(mr),
        .m_axis_tlast(ml), .m_axis_tuser(mu), .m_axis_err_tvalid(me),
        .pkt_cnt_0(pc0), .pkt_cnt_1(pc1), .err_cnt_0(ec0), .err_cnt_1(ec1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic enqueue(input int p, input int len, input bit err);
        pkt_t pk;
        pk.len  = len;
        pk.err  = err;
        pk.base = 8'(p * 128) + nb[p] * 8'd13;
        nb[p]++;
        sq[p].push_back(pk);
        oq[p].push_back(pk);
    endtask

    // One clock: drive sources, sample at mid-cycle, score, advance past the next rising edge
    task automatic cycle();
        logic hs0, hs1, ohs;
        pkt_t pk;
        for (int p = 0; p < 2; p++) begin
            if (sq[p].size() == 0) begin
                v[p] = 1'b0; pres[p] = 1'b0; l[p] = 1'b0; e[p] = 1'b0;
            end else begin
                if (!pres[p])
                    pres[p] = $urandom_range(99) >= gap_pct;
                v[p] = pres[p];
                d[p] = sq[p][0].base + 8'(beat[p]);
                l[p] = beat[p] == sq[p][0].len - 1;
                e[p] = l[p] & sq[p][0].err;
            end
        end
        mr = $urandom_range(99) < rdy_pct;
        #1;
        if ((v[0] | v[1]) && fv < 0) fv = cyc;
        if (mv && fo < 0) fo = cyc;
        chk("counters", 32'({pc0, pc1, ec0, ec1}), 32'({pcnt[0], pcnt[1], ecnt[0], ecnt[1]}));
        chk("tready_excl", 32'(r[0] & r[1]), 0);
        if (ended) chk("idle_gap", 32'(mv), 0);
        ended = 1'b0;
        if (mv && in_pkt) chk("tuser_const", 32'(mu), 32'(cur_src));
        hs0 = v[0] & r[0];
        hs1 = v[1] & r[1];
        ohs = mv & mr;
        chk("handshake", 32'(ohs), 32'(hs0 | hs1));
        if (ohs) begin
            if (!in_pkt) begin
                in_pkt = 1'b1;
                cur_src = mu;
                obeat = 0;
                if (exp_src.size() > 0) chk("order", 32'(mu), exp_src.pop_front());
            end
            chk("pkt_expected", 32'(oq[cur_src].size() > 0), 1);
            if (oq[cur_src].size() > 0) begin
                pk = oq[cur_src][0];
                chk("beat", 32'({md, ms, ml, me}),
                    32'({pk.base + 8'(obeat), 1'b1, obeat == pk.len - 1, pk.err && obeat == pk.len - 1}));
                obeat++;
                if (obeat == pk.len) begin
                    void'(oq[cur_src].pop_front());
                    in_pkt = 1'b0;
                    ended = 1'b1;
                    pcnt[cur_src]++;
                    if (pk.err) ecnt[cur_src]++;
                end
            end
        end
        for (int p = 0; p < 2; p++) begin
            if (v[p] & r[p]) begin
                beat[p]++;
                pres[p] = 1'b0;
                if (beat[p] == sq[p][0].len) begin
                    void'(sq[p].pop_front());
                    beat[p] = 0;
                end
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input int limit);
        int n = 0;
        while ((sq[0].size() > 0 || sq[1].size() > 0 || in_pkt) && n < limit) begin
            cycle();
            n++;
        end
        chk("drained", sq[0].size() + sq[1].size(), 0);
    endtask

    // A packet cut by reset restarts as a new packet from the next unsent beat
    task automatic do_reset();
        pkt_t pk;
        rstn = 1'b0;
        v[0] = 1'b0; v[1] = 1'b0;
        mr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_outputs", 32'({md, ms, mv, ml, mu, me, r[0], r[1]}), 0);
        chk("rst_counters", 32'({pc0, pc1, ec0, ec1}), 0);
        rstn = 1'b1;
        if (in_pkt) begin
            pk = oq[cur_src].pop_front();
            pk.base = pk.base + 8'(obeat);
            pk.len = pk.len - obeat;
            oq[cur_src].push_front(pk);
        end
        for (int p = 0; p < 2; p++) begin
            pcnt[p] = '0; ecnt[p] = '0; pres[p] = 1'b0;
        end
        in_pkt = 1'b0; obeat = 0; ended = 1'b0;
    endtask

    initial begin
        for (int p = 0; p < 2; p++) begin
            d[p] = '0; s[p] = 1'b1; v[p] = 1'b0; l[p] = 1'b0; e[p] = 1'b0;
            beat[p] = 0; pres[p] = 1'b0; nb[p] = '0; pcnt[p] = '0; ecnt[p] = '0;
        end
        rstn = 1'b0; mr = 1'b0; in_pkt = 1'b0; cur_src = 1'b0; ended = 1'b0; obeat = 0;
        do_reset();

        enqueue(0, 64, 1'b0);
        fv = -1; fo = -1;
        run(200);
        chk("first_beat_latency", fo - fv, 1);
        chk("t1_pkt_cnt_0", 32'(pc0), 1);
        chk("t1_err_cnt_0", 32'(ec0), 0);

        do_reset();
        exp_src = {0, 1, 0, 1, 0, 1, 0, 1};
        for (int i = 0; i < 4; i++) begin
            enqueue(0, 60, 1'b0);
            enqueue(1, 60, 1'b0);
        end
        run(1000);
        chk("rr_order_consumed", exp_src.size(), 0);
        chk("rr_pkt_cnt_0", 32'(pc0), 4);
        chk("rr_pkt_cnt_1", 32'(pc1), 4);

        enqueue(1, 10, 1'b1);
        run(100);
        chk("err_pkt_cnt_1", 32'(pc1), 5);
        chk("err_err_cnt_1", 32'(ec1), 1);
        chk("err_err_cnt_0", 32'(ec0), 0);

        gap_pct = 30; rdy_pct = 70;
        for (int i = 0; i < 40; i++)
            enqueue(int'($urandom_range(1)), int'($urandom_range(1, 250)), $urandom_range(3) == 0);
        run(40000);
        gap_pct = 0; rdy_pct = 100;

        do_reset();
        enqueue(0, 100, 1'b0);
        for (int n = 0; n < 200 && beat[0] < 20; n++)
            cycle();
        chk("mid_beat_reached", beat[0], 20);
        do_reset();
        run(300);
        chk("mid_pkt_cnt_0", 32'(pc0), 1);
        chk("mid_pkt_cnt_1", 32'(pc1), 0);

        do_reset();
        for (int i = 0; i < 15; i++)
            enqueue(0, 1, 1'b0);
        run(200);
        chk("wrap_all_ones", 32'(pc0), 15);
        enqueue(0, 1, 1'b0);
        run(20);
        chk("wrap_to_zero", 32'(pc0), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
